// File: rtl/ps2_pkg.sv
// PS/2 set-2 scancode constants and sequence-state type
// shared by the key tracker and its code-match table.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam logic [7:0] PS2_SPACE = 8'h29;
  localparam logic [7:0] PS2_RIGHT = 8'h23;
  localparam logic [7:0] PS2_LEFT  = 8'h1C;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } ps2_seq_state_t;

  function automatic logic is_prefix(logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK) ||
           (b == PS2_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_code_match.sv
// Combinational key table lookup: byte+ext -> hit vector.
// Ports: i_byte, i_ext in; o_hit[NUM_KEYS] out.
module ps2_code_match #(
  parameter int                    NUM_KEYS = 3,
  parameter logic [NUM_KEYS*8-1:0] KEYCODES = 24'h1C2329,
  parameter logic [NUM_KEYS-1:0]   KEY_EXT  = '0
) (
  input  logic [7:0]          i_byte,
  input  logic                i_ext,
  output logic [NUM_KEYS-1:0] o_hit
);

  always_comb begin
    o_hit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      o_hit[i] = (i_byte == KEYCODES[i*8 +: 8]) &&
                 (i_ext == KEY_EXT[i]);
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 decoder tracking held state of NUM_KEYS keys.
// Ports: clk, rst_n, rx_byte/rx_valid, clear in;
// key_held, key_press, key_release, seq_err out.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS    = 3,
  parameter logic [NUM_KEYS*8-1:0] KEYCODES    =
    {PS2_LEFT, PS2_RIGHT, PS2_SPACE},
  parameter logic [NUM_KEYS-1:0]   KEY_EXT     = '0,
  parameter int                    TIMEOUT_CYC = 65000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_byte,
  input  logic                rx_valid,
  input  logic                clear,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                seq_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYC - 1);

  ps2_seq_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_tcnt, w_tcnt_nxt;
  logic [2:0] r_pcnt, w_pcnt_nxt;
  logic [NUM_KEYS-1:0] r_held, w_held_nxt;
  logic [NUM_KEYS-1:0] r_press, w_press_nxt;
  logic [NUM_KEYS-1:0] r_rel, w_rel_nxt;
  logic [NUM_KEYS-1:0] w_hit;
  logic r_err, w_err_nxt;
  logic w_ext, w_pfx, w_make, w_brk;

  // Extended flag applies to the byte after E0 / E0 F0.
  assign w_ext = (r_state == ST_EXT) ||
                 (r_state == ST_EXT_BRK);
  assign w_pfx = is_prefix(rx_byte);

  ps2_code_match #(
    .NUM_KEYS (NUM_KEYS),
    .KEYCODES (KEYCODES),
    .KEY_EXT  (KEY_EXT)
  ) u_match (
    .i_byte (rx_byte),
    .i_ext  (w_ext),
    .o_hit  (w_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tcnt  <= '0;
      r_pcnt  <= '0;
      r_held  <= '0;
      r_press <= '0;
      r_rel   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_held  <= w_held_nxt;
      r_press <= w_press_nxt;
      r_rel   <= w_rel_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_pcnt_nxt  = r_pcnt;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_err_nxt   = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_tcnt_nxt  = '0;
      w_pcnt_nxt  = '0;
    end else if (rx_valid) begin
      w_tcnt_nxt = '0;
      unique case (r_state)
        ST_IDLE: begin
          unique case (1'b1)
            (rx_byte == PS2_EXT): w_state_nxt = ST_EXT;
            (rx_byte == PS2_BRK): w_state_nxt = ST_BRK;
            (rx_byte == PS2_PAUSE): begin
              w_state_nxt = ST_PAUSE;
              w_pcnt_nxt  = PAUSE_SKIP;
            end
            default: w_make = 1'b1;
          endcase
        end
        ST_EXT: begin
          if (rx_byte == PS2_BRK) begin
            w_state_nxt = ST_EXT_BRK;
          end else begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = w_pfx;
            w_make      = !w_pfx;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = w_pfx;
          w_brk       = !w_pfx;
        end
        ST_PAUSE: begin
          w_pcnt_nxt = r_pcnt - 3'd1;
          if (r_pcnt == 3'd1) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE) begin
      // Idle gap inside a multi-byte sequence.
      if (r_tcnt == TLAST) begin
        w_state_nxt = ST_IDLE;
        w_tcnt_nxt  = '0;
        w_pcnt_nxt  = '0;
        w_err_nxt   = 1'b1;
      end else begin
        w_tcnt_nxt = r_tcnt + CW'(1);
      end
    end
  end

  always_comb begin
    w_held_nxt  = r_held;
    w_press_nxt = '0;
    w_rel_nxt   = '0;
    if (clear) begin
      w_held_nxt = '0;
    end else if (w_make) begin
      w_press_nxt = w_hit & ~r_held;
      w_held_nxt  = r_held | w_hit;
    end else if (w_brk) begin
      w_rel_nxt  = w_hit & r_held;
      w_held_nxt = r_held & ~w_hit;
    end
  end

  assign key_held    = r_held;
  assign key_press   = r_press;
  assign key_release = r_rel;
  assign seq_err     = r_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomised bench for ps2_key_tracker with a byte-level
// reference model plus directed literal checks.
module tb_ps2_key_tracker;

  localparam int NK = 5;
  localparam int T  = 20;
  // idx0=29 idx1=23 idx2=1C idx3=E0+74 idx4=23 (dup of idx1)
  localparam logic [NK*8-1:0] KC = 40'h23741C2329;
  localparam logic [NK-1:0]   KX = 5'b01000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic rx_valid = 1'b0;
  logic clear = 1'b0;
  logic [NK-1:0] key_held, key_press, key_release;
  logic seq_err;

  always #5 clk = ~clk;

  ps2_key_tracker #(
    .NUM_KEYS    (NK),
    .KEYCODES    (KC),
    .KEY_EXT     (KX),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .clear       (clear),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release),
    .seq_err     (seq_err)
  );

  int total = 0;
  int bad = 0;

  // reference model
  bit [NK-1:0] m_held, e_held, e_press, e_rel;
  bit e_err;
  bit m_ext, m_brk;
  int m_pause, m_idle;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit is_pfx(logic [7:0] b);
    return b == 8'hE0 || b == 8'hF0 || b == 8'hE1;
  endfunction

  task automatic seq_reset();
    m_ext = 0;
    m_brk = 0;
    m_pause = 0;
  endtask

  task automatic model_reset();
    seq_reset();
    m_idle = 0;
    m_held = '0;
    e_held = '0;
    e_press = '0;
    e_rel = '0;
    e_err = 0;
  endtask

  task automatic key_event(bit mk, bit e, logic [7:0] b);
    for (int i = 0; i < NK; i++) begin
      if (KC[i*8 +: 8] == b && KX[i] == e) begin
        if (mk && !m_held[i]) begin
          m_held[i] = 1;
          e_press[i] = 1;
        end
        if (!mk && m_held[i]) begin
          m_held[i] = 0;
          e_rel[i] = 1;
        end
      end
    end
  endtask

  task automatic model_step(bit c, bit v, logic [7:0] b);
    e_press = '0;
    e_rel = '0;
    e_err = 0;
    if (c) begin
      m_held = '0;
      seq_reset();
      m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      if (m_pause > 0) begin
        m_pause--;
      end else if (!m_ext && !m_brk) begin
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE1) m_pause = 7;
        else key_event(1, 0, b);
      end else if (m_brk) begin
        if (is_pfx(b)) e_err = 1;
        else key_event(0, m_ext, b);
        seq_reset();
      end else begin
        if (b == 8'hF0) begin
          m_brk = 1;
        end else begin
          if (is_pfx(b)) e_err = 1;
          else key_event(1, 1, b);
          seq_reset();
        end
      end
    end else if (m_ext || m_brk || m_pause > 0) begin
      m_idle++;
      if (m_idle == T) begin
        e_err = 1;
        seq_reset();
        m_idle = 0;
      end
    end
    e_held = m_held;
  endtask

  task automatic compare();
    chk("held", 32'(key_held), 32'(e_held));
    chk("press", 32'(key_press), 32'(e_press));
    chk("release", 32'(key_release), 32'(e_rel));
    chk("seq_err", 32'(seq_err), 32'(e_err));
  endtask

  // drive at negedge, DUT samples at posedge, check next negedge
  task automatic cyc(bit c, bit v, logic [7:0] b);
    clear = c;
    rx_valid = v;
    rx_byte = b;
    model_step(c, v, b);
    @(negedge clk);
    clear = 0;
    rx_valid = 0;
    compare();
  endtask

  task automatic send(logic [7:0] b);
    cyc(0, 1, b);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00);
  endtask

  logic [7:0] pool [10];

  initial begin
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h29, 8'h23,
             8'h1C, 8'h74, 8'h12, 8'h00, 8'hF0};
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_held", 32'(key_held), 32'h0);
    chk("rst_press", 32'(key_press), 32'h0);
    chk("rst_rel", 32'(key_release), 32'h0);
    chk("rst_err", 32'(seq_err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'h29);
    chk("make29_held", 32'(key_held), 32'h01);
    chk("make29_press", 32'(key_press), 32'h01);
    idle(1);
    chk("make29_pulse_end", 32'(key_press), 32'h0);
    send(8'h29);
    chk("typematic1", 32'(key_press), 32'h0);
    send(8'h29);
    chk("typematic2", 32'(key_held), 32'h01);
    send(8'hF0);
    send(8'h29);
    chk("brk29_rel", 32'(key_release), 32'h01);
    chk("brk29_held", 32'(key_held), 32'h0);

    send(8'hE0);
    send(8'h74);
    chk("ext74_held", 32'(key_held), 32'h08);
    send(8'h74);
    chk("bare74_held", 32'(key_held), 32'h08);
    chk("bare74_press", 32'(key_press), 32'h0);
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    chk("ext74_rel", 32'(key_release), 32'h08);

    send(8'h23);
    chk("dup23_press", 32'(key_press), 32'h12);

    send(8'hE0);
    idle(T - 1);
    chk("to_not_yet", 32'(seq_err), 32'h0);
    idle(1);
    chk("to_err", 32'(seq_err), 32'h1);
    chk("to_keep_held", 32'(key_held), 32'h12);
    send(8'h1C);
    chk("after_to_1C", 32'(key_held), 32'h16);

    // byte on the timeout cycle wins over the timeout
    send(8'hE0);
    idle(T - 1);
    send(8'h74);
    chk("to_race_err", 32'(seq_err), 32'h0);
    chk("to_race_held", 32'(key_held), 32'h1E);

    send(8'hE0);
    send(8'hE1);
    chk("ext_pfx_err", 32'(seq_err), 32'h1);

    send(8'hF0);
    send(8'h23);
    send(8'hE1);
    send(8'h14);
    send(8'h77);
    send(8'hE1);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    send(8'h77);
    chk("pause_quiet", 32'(seq_err), 32'h0);
    send(8'h23);
    chk("after_pause23", 32'(key_press), 32'h12);

    cyc(1, 1, 8'h29);
    chk("clear_held", 32'(key_held), 32'h0);
    chk("clear_press", 32'(key_press), 32'h0);

    send(8'h29);
    send(8'hE0);
    send(8'hF0);
    rst_n = 1'b0;
    #1;
    chk("arst_held", 32'(key_held), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h29);
    chk("post_rst_press", 32'(key_press), 32'h01);

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r == 0) cyc(1, ($urandom_range(0, 1) == 1), 8'h29);
      else if (r == 1) idle(T + 3);
      else if (r < 120) send(pool[$urandom_range(0, 9)]);
      else idle(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
